// File: rtl/mem_fabric_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_fabric_if
// Description : CPU-side request/response bus plus the slave select, slave
//               read-data/ready and sticky-error signals of the memory fabric.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_fabric_if #(
    parameter int NSLV = 6
);
    logic                   mem_valid;
    logic [31:0]            mem_addr;
    logic [3:0]             mem_wstrb;
    logic [31:0]            mem_rdata;
    logic                   mem_ready;
    logic [NSLV-1:0]        slv_sel;
    logic [32*NSLV-1:0]     slv_rdata;
    logic [NSLV-1:0]        slv_rdy;
    logic                   err_clr;
    logic                   bus_err;
    logic [31:0]            err_addr;

    // Fabric side
    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, slv_rdata, slv_rdy, err_clr,
        output mem_rdata, mem_ready, slv_sel, bus_err, err_addr
    );

    // CPU / environment side
    modport master (
        output mem_valid, mem_addr, mem_wstrb, slv_rdata, slv_rdy, err_clr,
        input  mem_rdata, mem_ready, slv_sel, bus_err, err_addr
    );
endinterface
`default_nettype wire

// File: rtl/mem_fabric.sv
`default_nettype none
// ============================================================================
// Module      : mem_fabric
// Description : Single-master memory fabric. Decodes mem_addr[31:28] to one of
//               NSLV slaves, inserts per-slave wait states or waits on an
//               external ready with timeout, and keeps a sticky first-error
//               address for timeouts and unmapped accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fabric #(
    parameter int          NSLV    = 6,
    parameter logic [63:0] WAITS   = 64'h0,
    parameter logic [15:0] EXT_RDY = 16'h0010,
    parameter int          TIMEOUT = 255
) (
    input  wire logic      clk24,
    input  wire logic      reset,
    mem_fabric_if.slave    bus
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_WAIT     = 2'd1;
    localparam logic [1:0]  c_DONE     = 2'd2;
    localparam logic [4:0]  c_NSLV     = 5'(NSLV);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [15:0]        r_cnt;
    logic [3:0]         r_idx;
    logic               r_ext;
    logic               r_unmapped;
    logic               r_bus_err;
    logic [31:0]        r_err_addr;

    logic [3:0]         w_req_idx;
    logic               w_req_mapped;
    logic [3:0]         w_req_waits;
    logic [31:0]        w_slv_data;
    logic               w_slv_rdy;
    logic [NSLV-1:0]    w_sel;
    logic               w_ready;
    logic [31:0]        w_rdata;
    logic               w_err_set;
    logic               w_tmo;

    assign w_req_idx    = bus.mem_addr[31:28];
    assign w_req_mapped = ({1'b0, w_req_idx} < c_NSLV);
    assign w_req_waits  = WAITS[{w_req_idx, 2'b00} +: 4];

    // Route the latched slave's read data and ready to the response path
    always_comb begin
        w_slv_data = 32'h0;
        w_slv_rdy  = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_idx == 4'(i)) begin
                w_slv_data = bus.slv_rdata[32*i +: 32];
                w_slv_rdy  = bus.slv_rdy[i];
            end
        end
    end

    // One-hot select straight from the address, suppressed in DONE so a
    // still-high mem_valid cannot look like a new access
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_sel[i] = bus.mem_valid & (bus.mem_addr[31:28] == 4'(i)) & (r_state != c_DONE);
        end
    end

    // FSM state register
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: WAIT ends on the same cycle mem_ready is presented
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.mem_valid) w_state_nxt = c_WAIT;
            c_WAIT:  if (w_ready)       w_state_nxt = c_DONE;
            c_DONE:                     w_state_nxt = c_IDLE;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: ready, read data and error-set request, all decided in WAIT
    always_comb begin
        w_ready   = 1'b0;
        w_rdata   = 32'h0;
        w_err_set = 1'b0;
        w_tmo     = 1'b0;
        if (r_state == c_WAIT) begin
            if (r_unmapped) begin
                w_ready   = 1'b1;
                w_err_set = 1'b1;
            end else if (r_ext) begin
                // A ready arriving on the limit cycle is a normal completion
                w_tmo     = (r_cnt == c_TMO_LAST) & ~w_slv_rdy;
                w_ready   = w_slv_rdy | w_tmo;
                w_err_set = w_tmo;
                w_rdata   = w_tmo ? 32'h0 : w_slv_data;
            end else begin
                w_ready   = (r_cnt == 16'd0);
                w_rdata   = w_slv_data;
            end
        end
    end

    // Request latch and wait/timeout counter
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_cnt      <= 16'd0;
            r_idx      <= 4'd0;
            r_ext      <= 1'b0;
            r_unmapped <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.mem_valid) begin
                        r_idx      <= w_req_idx;
                        r_unmapped <= ~w_req_mapped;
                        r_ext      <= w_req_mapped & EXT_RDY[w_req_idx];
                        if (w_req_mapped && !EXT_RDY[w_req_idx]) begin
                            r_cnt <= {12'd0, w_req_waits};
                        end else begin
                            r_cnt <= 16'd0;
                        end
                    end
                end
                c_WAIT: begin
                    if (!w_ready && !r_unmapped) begin
                        if (r_ext) begin
                            r_cnt <= r_cnt + 16'd1;
                        end else if (r_cnt != 16'd0) begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Sticky error: first fault address is kept; a set beats a simultaneous clear
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'h0;
        end else if (w_err_set) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err || bus.err_clr) begin
                r_err_addr <= bus.mem_addr;
            end
        end else if (bus.err_clr) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'h0;
        end
    end

    assign bus.mem_ready = w_ready;
    assign bus.mem_rdata = w_rdata;
    assign bus.slv_sel   = w_sel;
    assign bus.bus_err   = r_bus_err;
    assign bus.err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fabric
// Description : Directed self-checking bench for mem_fabric: wait states,
//               external ready, timeout, unmapped access, sticky error, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fabric;

    localparam int          c_NSLV    = 6;
    // slave0: 0 waits, slave1: 3 waits, slave2: 15 waits, slave4: external
    localparam logic [63:0] c_WAITS   = 64'h0000_0000_0000_0F30;
    localparam logic [15:0] c_EXT_RDY = 16'h0010;
    localparam int          c_TIMEOUT = 255;

    logic clk24;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_cyc;

    mem_fabric_if #(.NSLV(c_NSLV)) bus ();

    mem_fabric #(
        .NSLV    (c_NSLV),
        .WAITS   (c_WAITS),
        .EXT_RDY (c_EXT_RDY),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk24 (clk24),
        .reset (reset),
        .bus   (bus)
    );

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk24);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic [3:0] s);
        bus.mem_valid = v;
        bus.mem_addr  = a;
        bus.mem_wstrb = s;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drv(1'b0, 32'h0, 4'h0);
        bus.err_clr   = 1'b0;
        bus.slv_rdy   = '0;
        bus.slv_rdata = '0;
        bus.slv_rdata[31:0]    = 32'h1234_5678;
        bus.slv_rdata[63:32]   = 32'hCAFE_F00D;
        bus.slv_rdata[95:64]   = 32'h2222_2222;
        bus.slv_rdata[159:128] = 32'h4444_4444;

        // Reset state
        step();
        step();
        chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
        chk("rst_err_addr", bus.err_addr, 32'h0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, bus.mem_ready}, 32'd0);

        // Zero-wait read from slave 0
        drv(1'b1, 32'h0000_0010, 4'h0);
        #1;
        chk("t1_sel", {26'd0, bus.slv_sel}, 32'h01);
        chk("t1_idle_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        chk("t1_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t1_rdata", bus.mem_rdata, 32'h1234_5678);
        bus.mem_valid = 1'b0;
        step();
        chk("t1_done_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("t1_done_rdata", bus.mem_rdata, 32'h0);
        step();

        // Three-wait write to slave 1: ready only on cycle 4
        drv(1'b1, 32'h1000_0000, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("t2_ready", {31'd0, bus.mem_ready}, {31'd0, (c == 4)});
            chk("t2_sel", {26'd0, bus.slv_sel}, 32'h02);
        end
        chk("t2_rdata", bus.mem_rdata, 32'hCAFE_F00D);
        bus.mem_valid = 1'b0;
        step();
        chk("t2_done_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();

        // External slave 4: ready follows slv_rdy on cycle 7
        drv(1'b1, 32'h4000_0000, 4'h0);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("t3_wait_ready", {31'd0, bus.mem_ready}, 32'd0);
        end
        step();
        bus.slv_rdy[4] = 1'b1;
        #1;
        chk("t3_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t3_rdata", bus.mem_rdata, 32'h4444_4444);
        bus.mem_valid = 1'b0;
        step();
        bus.slv_rdy[4] = 1'b0;
        #1;
        chk("t3_done_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("t3_bus_err", {31'd0, bus.bus_err}, 32'd0);
        step();

        // slv_rdy on the limit cycle (255) is a normal completion
        drv(1'b1, 32'h4000_0000, 4'h0);
        repeat (254) step();
        chk("t4_pre_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        bus.slv_rdy[4] = 1'b1;
        #1;
        chk("t4_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t4_rdata", bus.mem_rdata, 32'h4444_4444);
        bus.mem_valid = 1'b0;
        step();
        bus.slv_rdy[4] = 1'b0;
        chk("t4_bus_err", {31'd0, bus.bus_err}, 32'd0);
        step();

        // No slv_rdy: forced ready after TIMEOUT cycles, error captured
        drv(1'b1, 32'h4000_0000, 4'h0);
        n_cyc = 0;
        do begin
            step();
            n_cyc++;
        end while (!bus.mem_ready && n_cyc < 300);
        chk("t5_cycles", 32'(n_cyc), 32'd255);
        chk("t5_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t5_rdata", bus.mem_rdata, 32'h0);
        chk("t5_err_early", {31'd0, bus.bus_err}, 32'd0);
        bus.mem_valid = 1'b0;
        step();
        chk("t5_bus_err", {31'd0, bus.bus_err}, 32'd1);
        chk("t5_err_addr", bus.err_addr, 32'h4000_0000);
        chk("t5_done_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t5_clr_err", {31'd0, bus.bus_err}, 32'd0);
        chk("t5_clr_addr", bus.err_addr, 32'h0);

        // Unmapped read
        drv(1'b1, 32'hA000_0004, 4'h0);
        #1;
        chk("t6_sel", {26'd0, bus.slv_sel}, 32'h0);
        step();
        chk("t6_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t6_rdata", bus.mem_rdata, 32'h0);
        chk("t6_err_pre", {31'd0, bus.bus_err}, 32'd0);
        bus.mem_valid = 1'b0;
        step();
        chk("t6_bus_err", {31'd0, bus.bus_err}, 32'd1);
        chk("t6_err_addr", bus.err_addr, 32'hA000_0004);
        chk("t6_done_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();

        // Second fault (unmapped write) keeps the first address
        drv(1'b1, 32'hB000_0000, 4'hF);
        step();
        chk("t6b_ready", {31'd0, bus.mem_ready}, 32'd1);
        bus.mem_valid = 1'b0;
        step();
        chk("t6b_err_addr", bus.err_addr, 32'hA000_0004);
        chk("t6b_bus_err", {31'd0, bus.bus_err}, 32'd1);
        step();

        // Clear
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t6_clr_err", {31'd0, bus.bus_err}, 32'd0);
        chk("t6_clr_addr", bus.err_addr, 32'h0);

        // New fault after clear is captured
        drv(1'b1, 32'hB000_0000, 4'h0);
        step();
        bus.mem_valid = 1'b0;
        step();
        chk("t6c_err_addr", bus.err_addr, 32'hB000_0000);
        step();

        // Fault coinciding with err_clr: the new address wins
        drv(1'b1, 32'hC000_0008, 4'h0);
        step();
        bus.err_clr = 1'b1;
        #1;
        chk("t6d_ready", {31'd0, bus.mem_ready}, 32'd1);
        bus.mem_valid = 1'b0;
        step();
        bus.err_clr = 1'b0;
        chk("t6d_bus_err", {31'd0, bus.bus_err}, 32'd1);
        chk("t6d_err_addr", bus.err_addr, 32'hC000_0008);
        step();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;

        // Reset in the middle of a 15-wait access to slave 2
        drv(1'b1, 32'h2000_0000, 4'h0);
        repeat (5) step();
        chk("t7_wait_ready", {31'd0, bus.mem_ready}, 32'd0);
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        step();
        chk("t7_rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        reset = 1'b0;
        step();
        // Back-to-back request in the first cycle after release
        drv(1'b1, 32'h0000_0010, 4'h0);
        #1;
        chk("t7_first_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        chk("t7_b2b_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t7_b2b_rdata", bus.mem_rdata, 32'h1234_5678);
        bus.mem_valid = 1'b0;
        step();
        chk("t7_b2b_done", {31'd0, bus.mem_ready}, 32'd0);
        n_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.mem_ready !== 1'b0) n_cyc++;
        end
        chk("t7_no_late_ready", 32'(n_cyc), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
